config_source_arbiter: RTL and testbench
========================================

# config_source_arbiter

Shares the fabric configuration write port (32-bit `WriteData` / `WriteStrobe` / `FSM_Reset`) between several bitstream sources, such as UART, parallel and USB loaders. It sits directly upstream of the configuration frame FSM. It grants the port to one active source at a time, and re-arms the frame FSM with a clean `FSM_Reset` rising edge on every new grant. It holds the grant for a whole bitstream and releases it on source deactivation or an idle timeout.

## Interface
- `NUM_SOURCES`, 2: number of requesters, 2..4.
- `IDLE_TIMEOUT`, 65535: cycles without a word before a grant is revoked; must be ≥1 and <2^24.
- `RESET_CYCLES`, 2: cycles `FSM_Reset` is held high after a grant; ≥1.

Ports:
- `CLK` in 1: clock.
- `resetn` in 1: asynchronous, active-low reset.
- `src_active` in `NUM_SOURCES`: per-source "bitstream session open" level.
- `src_valid` in `NUM_SOURCES`: per-source word valid.
- `src_data` in `NUM_SOURCES*32`: source i occupies bits [32i+31:32i].
- `src_ready` out `NUM_SOURCES`: per-source word accepted (combinational).
- `WriteData` out 32: word to the frame FSM (registered).
- `WriteStrobe` out 1: one-cycle write strobe per word (registered).
- `FSM_Reset` out 1: frame-FSM resync request (registered).
- `grant` out `NUM_SOURCES`: one-hot owner, all-zero when idle (registered).
- `busy` out 1: OR of `grant`.
- `timeout_evt` out 1: one-cycle pulse when a grant is revoked by timeout.

## Operation
- States: IDLE, ARM, OWN, RELEASE; 2-bit encoding.
- IDLE: `FSM_Reset`=0. If any `src_active` is high, pick a source by round-robin starting at `rr_ptr`. Register `grant`, load the arm counter with `RESET_CYCLES`, and go to ARM.
- ARM: `FSM_Reset`=1 and `src_ready`=0. Decrement the counter; on 1, go to OWN. `FSM_Reset` was low in IDLE, so the downstream FSM always sees a rising edge.
- OWN:
  - `FSM_Reset`=0.
  - `src_ready[g]`=1 for the granted source; all others 0.
  - Each cycle with `src_valid[g]`: register `WriteData`=`src_data[g]` and `WriteStrobe`=1 for the next cycle, and clear the idle counter. Otherwise `WriteStrobe`=0 and the idle counter increments.
  - Go to RELEASE if `src_active[g]`=0. This wins over a same-cycle valid word, which is not accepted: `src_ready` is gated by `src_active`.
  - Go to RELEASE if the idle counter reaches `IDLE_TIMEOUT-1` with no valid; pulse `timeout_evt`.
- RELEASE: `src_ready`=0, `grant` cleared, `rr_ptr` set to `g+1` mod `NUM_SOURCES`, go to IDLE. A source still asserting active after timeout is re-eligible once its round-robin turn comes.
- Non-granted sources are never stalled by error; they simply see `src_ready`=0.
- Idle counter is 24 bits and saturates; it is cleared on entry to OWN.

## Timing
- Reset values: `WriteData`=0, `WriteStrobe`=0, `FSM_Reset`=0, `grant`=0, `busy`=0, `timeout_evt`=0, state=IDLE, `rr_ptr`=0, counters=0.
- Request to first `FSM_Reset` high: 1 cycle (IDLE→ARM register).
- `FSM_Reset` high for exactly `RESET_CYCLES` cycles. The first cycle with `src_ready[g]`=1 follows immediately.
- Data latency: accepted word appears on `WriteData`/`WriteStrobe` exactly 1 cycle after the valid&ready cycle. Back-to-back words give back-to-back strobes; no bubbles.
- Release: `grant` drops 1 cycle after the RELEASE decision. The minimum gap before a new grant's ARM is 1 IDLE cycle.
- Asynchronous reset mid-transfer clears everything immediately; there is no partial-word strobe afterwards.

## Structure
- Shared package `config_pkg`: state enum (IDLE/ARM/OWN/RELEASE), word width constant 32, sync pattern `32'hFAB0_FAB1` for benches.
- One sub-module: `rr_arbiter` (parameterised one-hot round-robin pick from a request vector and pointer; combinational).
- All other logic stays in the top: FSM, counters, output registers.

## Test plan
- Reset, then source 0 active with 3 words 0xFAB0_FAB1, 0x0000_0001, 0xDEAD_BEEF:
  - `grant`=01;
  - `FSM_Reset` high 2 cycles;
  - 3 consecutive `WriteStrobe` pulses carrying those values, each 1 cycle after acceptance.
- Sources 0 and 1 active simultaneously from reset:
  - source 0 granted first;
  - after source 0 drops active, source 1 is granted with a fresh `FSM_Reset` edge;
  - no `WriteStrobe` carries source 1 data during source 0 ownership.
- `IDLE_TIMEOUT`=16, source 1 granted then silent:
  - `timeout_evt` pulses on idle cycle 16;
  - `grant` clears, then source 0 (pending) is granted before source 1 again.
- Same-cycle `src_active` fall and `src_valid` on the owner: `src_ready`=0, no `WriteStrobe` for that word, RELEASE follows.
- `resetn` asserted mid-stream (after 5 words): all outputs 0 immediately. After release, a new grant starts from source 0 with a full ARM phase.
- `NUM_SOURCES`=4, all active, each session of 2 words then inactive→active again: grants rotate 0,1,2,3,0 in order.

Source files
------------

// File: rtl/config_pkg.sv
// Shared types and constants for the configuration-port arbiter and its bench.
package config_pkg;

  localparam int WORD_W     = 32;
  localparam int IDLE_CNT_W = 24;
  localparam int ARM_CNT_W  = 16;

  localparam logic [WORD_W-1:0] SYNC_PATTERN = 32'hFAB0_FAB1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_OWN     = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  // Index of the next requester after idx, wrapping at n.
  function automatic int wrap_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot round-robin pick: the first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  int cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    cand    = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/config_source_arbiter.sv
// Shares the fabric configuration write port between bitstream sources, one
// whole session at a time, with a fresh FSM_Reset pulse on every grant.
module config_source_arbiter
  import config_pkg::*;
#(
  parameter int NUM_SOURCES  = 2,
  parameter int IDLE_TIMEOUT = 65535,
  parameter int RESET_CYCLES = 2
) (
  input  logic                          CLK,
  input  logic                          resetn,
  input  logic [NUM_SOURCES-1:0]        src_active,
  input  logic [NUM_SOURCES-1:0]        src_valid,
  input  logic [NUM_SOURCES*WORD_W-1:0] src_data,
  output logic [NUM_SOURCES-1:0]        src_ready,
  output logic [WORD_W-1:0]             WriteData,
  output logic                          WriteStrobe,
  output logic                          FSM_Reset,
  output logic [NUM_SOURCES-1:0]        grant,
  output logic                          busy,
  output logic                          timeout_evt
);

  localparam int IDX_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
  localparam logic [IDLE_CNT_W-1:0] IDLE_LIMIT = IDLE_CNT_W'(IDLE_TIMEOUT - 1);
  localparam logic [ARM_CNT_W-1:0]  ARM_LOAD   = ARM_CNT_W'(RESET_CYCLES);

  arb_state_e             state_reg, state_next;
  logic [IDX_W-1:0]       rr_ptr_reg, rr_ptr_next;
  logic [IDX_W-1:0]       owner_reg, owner_next;
  logic [NUM_SOURCES-1:0] grant_reg, grant_next;
  logic [ARM_CNT_W-1:0]   arm_cnt_reg, arm_cnt_next;
  logic [IDLE_CNT_W-1:0]  idle_cnt_reg, idle_cnt_next;
  logic [WORD_W-1:0]      write_data_reg, write_data_next;
  logic                   write_strobe_reg, write_strobe_next;
  logic                   fsm_reset_reg, fsm_reset_next;

  logic [NUM_SOURCES-1:0] pick_onehot;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;

  logic                   owner_active;
  logic                   owner_valid;
  logic [WORD_W-1:0]      owner_data;

  rr_arbiter #(
    .N     (NUM_SOURCES),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req     (src_active),
    .ptr     (rr_ptr_reg),
    .gnt     (pick_onehot),
    .gnt_idx (pick_idx),
    .any     (pick_valid)
  );

  assign owner_active = src_active[owner_reg];
  assign owner_valid  = src_valid[owner_reg];
  assign owner_data   = src_data[owner_reg*WORD_W +: WORD_W];

  // Ready is gated by active so a word arriving with session close is refused.
  generate
    for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_ready
      assign src_ready[gi] = (state_reg == ST_OWN) && (owner_reg == IDX_W'(gi)) && src_active[gi];
    end
  endgenerate

  always_comb begin
    state_next        = state_reg;
    rr_ptr_next       = rr_ptr_reg;
    owner_next        = owner_reg;
    grant_next        = grant_reg;
    arm_cnt_next      = arm_cnt_reg;
    idle_cnt_next     = idle_cnt_reg;
    write_data_next   = write_data_reg;
    write_strobe_next = 1'b0;
    timeout_evt       = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (pick_valid) begin
          state_next   = ST_ARM;
          grant_next   = pick_onehot;
          owner_next   = pick_idx;
          arm_cnt_next = ARM_LOAD;
        end
      end
      ST_ARM: begin
        arm_cnt_next = arm_cnt_reg - 1'b1;
        if (arm_cnt_reg <= 1) begin
          state_next    = ST_OWN;
          idle_cnt_next = '0;
        end
      end
      ST_OWN: begin
        if (!owner_active) begin
          state_next = ST_RELEASE;
          grant_next = '0;
        end else if (owner_valid) begin
          write_strobe_next = 1'b1;
          write_data_next   = owner_data;
          idle_cnt_next     = '0;
        end else if (idle_cnt_reg >= IDLE_LIMIT) begin
          state_next  = ST_RELEASE;
          grant_next  = '0;
          timeout_evt = 1'b1;
        end else if (idle_cnt_reg != '1) begin
          idle_cnt_next = idle_cnt_reg + 1'b1;
        end
      end
      ST_RELEASE: begin
        rr_ptr_next = IDX_W'(wrap_next(int'(owner_reg), NUM_SOURCES));
        state_next  = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        grant_next = '0;
      end
    endcase

    // High for exactly the ARM cycles; IDLE always precedes, giving a rising edge.
    fsm_reset_next = (state_next == ST_ARM);
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_reg        <= ST_IDLE;
      rr_ptr_reg       <= '0;
      owner_reg        <= '0;
      grant_reg        <= '0;
      arm_cnt_reg      <= '0;
      idle_cnt_reg     <= '0;
      write_data_reg   <= '0;
      write_strobe_reg <= 1'b0;
      fsm_reset_reg    <= 1'b0;
    end else begin
      state_reg        <= state_next;
      rr_ptr_reg       <= rr_ptr_next;
      owner_reg        <= owner_next;
      grant_reg        <= grant_next;
      arm_cnt_reg      <= arm_cnt_next;
      idle_cnt_reg     <= idle_cnt_next;
      write_data_reg   <= write_data_next;
      write_strobe_reg <= write_strobe_next;
      fsm_reset_reg    <= fsm_reset_next;
    end
  end

  assign WriteData   = write_data_reg;
  assign WriteStrobe = write_strobe_reg;
  assign FSM_Reset   = fsm_reset_reg;
  assign grant       = grant_reg;
  assign busy        = |grant_reg;

endmodule

// File: tb/tb_config_source_arbiter.sv
// Bench for config_source_arbiter: directed table, corner sequences, random run vs a session model.
module tb_config_source_arbiter;
  import config_pkg::*;

  localparam int N  = 4;
  localparam int T  = 16;
  localparam int RC = 2;

  logic           CLK = 1'b0;
  logic           resetn = 1'b1;
  logic [N-1:0]   act_i = '0;
  logic [N-1:0]   val_i = '0;
  logic [N*32-1:0] data_i = '0;
  logic [N-1:0]   src_ready;
  logic [31:0]    WriteData;
  logic           WriteStrobe;
  logic           FSM_Reset;
  logic [N-1:0]   grant;
  logic           busy;
  logic           timeout_evt;

  config_source_arbiter #(
    .NUM_SOURCES  (N),
    .IDLE_TIMEOUT (T),
    .RESET_CYCLES (RC)
  ) dut (
    .CLK         (CLK),
    .resetn      (resetn),
    .src_active  (act_i),
    .src_valid   (val_i),
    .src_data    (data_i),
    .src_ready   (src_ready),
    .WriteData   (WriteData),
    .WriteStrobe (WriteStrobe),
    .FSM_Reset   (FSM_Reset),
    .grant       (grant),
    .busy        (busy),
    .timeout_evt (timeout_evt)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Observed outputs of the most recent cycle
  logic [N-1:0] obs_grant, obs_ready;
  logic         obs_rst, obs_strobe, obs_busy, obs_to;
  logic [31:0]  obs_data;

  // Session-level reference model: owner (-1 none), cycles since grant, idle run
  int          m_owner, m_age, m_idle, m_ptr;
  bit          m_gap, m_strobe;
  logic [31:0] m_data;

  task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_age = 0; m_idle = 0; m_ptr = 0;
    m_gap = 0; m_strobe = 0; m_data = '0;
  endtask

  // Called at posedge+1: drive, sample at negedge, compare to model, advance to posedge+1.
  task automatic cycle(input logic [N-1:0] act, input logic [N-1:0] val, input logic [N*32-1:0] data);
    logic [N-1:0] e_grant, e_ready;
    logic         e_rst, e_to, owned, accept;
    bit           found;
    int           idx;
    act_i = act; val_i = val; data_i = data;
    @(negedge CLK);
    obs_grant = grant; obs_ready = src_ready; obs_rst = FSM_Reset;
    obs_strobe = WriteStrobe; obs_data = WriteData; obs_busy = busy; obs_to = timeout_evt;

    e_grant = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    e_rst   = (m_owner >= 0) && (m_age < RC);
    owned   = (m_owner >= 0) && (m_age >= RC);
    e_ready = (owned && act[m_owner]) ? e_grant : '0;
    e_to    = owned && act[m_owner] && !val[m_owner] && (m_idle == T - 1);
    chk("model", {obs_grant, obs_rst, obs_ready, obs_strobe, obs_data, obs_busy, obs_to},
        {e_grant, e_rst, e_ready, m_strobe, m_data, |e_grant, e_to});

    accept = owned && act[m_owner] && val[m_owner];
    if (accept) m_data = data[m_owner*32 +: 32];
    m_strobe = accept;
    if (m_owner >= 0) begin
      if (!owned) begin
        m_age++;
        if (m_age == RC) m_idle = 0;
      end else if (!act[m_owner] || e_to) begin
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
        m_gap = 1;
      end else if (accept) begin
        m_idle = 0;
      end else begin
        m_idle++;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!found && act[idx]) begin
          found = 1; m_owner = idx; m_age = 0;
        end
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0; act_i = '0; val_i = '0; data_i = '0;
    #1;
    chk("reset_state", {grant, FSM_Reset, src_ready, WriteStrobe, WriteData, busy, timeout_evt}, 64'd0);
    @(posedge CLK); @(posedge CLK); #1;
    resetn = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [N-1:0] act;
    logic [N-1:0] val;
    logic [31:0]  d0;
    logic [N-1:0] e_grant;
    logic         e_rst;
    logic [N-1:0] e_ready;
    logic         e_strobe;
    logic [31:0]  e_data;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n, bad;
    logic prev_rst;
    int words [N];
    logic [N-1:0] act_f, act_r, val_r, prev_g;
    int seq [$];
    int vprob;

    // Source 0 session: sync word, 1, DEADBEEF, then close
    tbl[0] = '{4'h1, 4'h0, 32'h0,         4'h0, 1'b0, 4'h0, 1'b0, 32'h0};
    tbl[1] = '{4'h1, 4'h1, SYNC_PATTERN,  4'h1, 1'b1, 4'h0, 1'b0, 32'h0};
    tbl[2] = '{4'h1, 4'h1, SYNC_PATTERN,  4'h1, 1'b1, 4'h0, 1'b0, 32'h0};
    tbl[3] = '{4'h1, 4'h1, SYNC_PATTERN,  4'h1, 1'b0, 4'h1, 1'b0, 32'h0};
    tbl[4] = '{4'h1, 4'h1, 32'h0000_0001, 4'h1, 1'b0, 4'h1, 1'b1, SYNC_PATTERN};
    tbl[5] = '{4'h1, 4'h1, 32'hDEAD_BEEF, 4'h1, 1'b0, 4'h1, 1'b1, 32'h0000_0001};
    tbl[6] = '{4'h1, 4'h0, 32'h0,         4'h1, 1'b0, 4'h1, 1'b1, 32'hDEAD_BEEF};
    tbl[7] = '{4'h0, 4'h0, 32'h0,         4'h1, 1'b0, 4'h0, 1'b0, 32'hDEAD_BEEF};
    tbl[8] = '{4'h0, 4'h0, 32'h0,         4'h0, 1'b0, 4'h0, 1'b0, 32'hDEAD_BEEF};
    tbl[9] = '{4'h0, 4'h0, 32'h0,         4'h0, 1'b0, 4'h0, 1'b0, 32'hDEAD_BEEF};

    model_reset();
    #3;
    do_reset();

    for (int r = 0; r < 10; r++) begin
      cycle(tbl[r].act, tbl[r].val, {96'h0, tbl[r].d0});
      chk($sformatf("tbl_row%0d", r), {obs_grant, obs_rst, obs_ready, obs_strobe, obs_data},
          {tbl[r].e_grant, tbl[r].e_rst, tbl[r].e_ready, tbl[r].e_strobe, tbl[r].e_data});
    end

    // Two sources from reset: 0 first, 1 after 0 closes with a fresh reset edge
    do_reset();
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      cycle(4'b0011, 4'b0011, {64'h0, 32'hB000_0000 + 32'(c), 32'hA000_0000 + 32'(c)});
      if (obs_grant == 4'b0001 && obs_strobe && obs_data[31:28] == 4'hB) bad++;
    end
    chk("b_first_grant", obs_grant, 4'b0001);
    prev_rst = obs_rst;
    for (int c = 0; c < 10; c++) begin
      cycle(4'b0010, 4'b0010, {64'h0, 32'hB000_0100 + 32'(c), 32'hA000_0100});
      if (obs_grant == 4'b0001 && obs_strobe && obs_data[31:28] == 4'hB) bad++;
      if (obs_grant == 4'b0010) break;
      prev_rst = obs_rst;
    end
    chk("b_src1_grant", obs_grant, 4'b0010);
    chk("b_src1_reset_edge", {prev_rst, obs_rst}, 2'b01);
    chk("b_no_cross_data", bad, 0);

    // Source 1 owns but stays silent while source 0 waits
    do_reset();
    cycle(4'b0010, 4'b0000, '0);
    k = 0;
    for (int c = 0; c < 40; c++) begin
      cycle(4'b0011, 4'b0000, '0);
      if (obs_ready[1]) k++;
      if (obs_to) break;
    end
    chk("c_timeout_idle_cycle", k, T);
    cycle(4'b0011, 4'b0000, '0);
    chk("c_grant_cleared", obs_grant, 4'b0000);
    for (int c = 0; c < 6; c++) begin
      cycle(4'b0011, 4'b0000, '0);
      if (obs_grant != 0) break;
    end
    chk("c_next_owner", obs_grant, 4'b0001);

    // Active falls in the same cycle as a valid word
    do_reset();
    for (int c = 0; c < 6; c++) begin
      cycle(4'b0001, 4'b0000, '0);
      if (obs_ready[0]) break;
    end
    chk("d_owned", obs_ready, 4'b0001);
    cycle(4'b0000, 4'b0001, {96'h0, 32'h5555_5555});
    chk("d_ready_gated", obs_ready, 4'b0000);
    cycle(4'b0000, 4'b0000, '0);
    chk("d_no_strobe", obs_strobe, 1'b0);
    chk("d_released", obs_grant, 4'b0000);

    // Reset in the middle of a stream, then a clean re-grant from source 0
    do_reset();
    n = 0;
    for (int c = 0; c < 20 && n < 5; c++) begin
      cycle(4'b0001, 4'b0001, {96'h0, 32'h7000_0000 + 32'(c)});
      if (obs_strobe) n++;
    end
    chk("e_words_before_reset", n, 5);
    do_reset();
    cycle(4'b1111, 4'b0000, '0);
    chk("e_idle_after_reset", obs_grant, 4'b0000);
    cycle(4'b1111, 4'b0000, '0);
    chk("e_arm1", {obs_grant, obs_rst, obs_ready}, {4'b0001, 1'b1, 4'b0000});
    cycle(4'b1111, 4'b0000, '0);
    chk("e_arm2", {obs_grant, obs_rst, obs_ready}, {4'b0001, 1'b1, 4'b0000});
    cycle(4'b1111, 4'b0000, '0);
    chk("e_own", {obs_grant, obs_rst, obs_ready}, {4'b0001, 1'b0, 4'b0001});

    // Four sources, two words per session then a one-cycle close
    do_reset();
    for (int i = 0; i < N; i++) words[i] = 0;
    act_f = 4'hF;
    prev_g = '0;
    for (int c = 0; c < 300 && seq.size() < 5; c++) begin
      cycle(act_f, 4'hF, {32'h3000_0000 + 32'(c), 32'h2000_0000 + 32'(c),
                          32'h1000_0000 + 32'(c), 32'h0000_0000 + 32'(c)});
      act_f = 4'hF;
      for (int i = 0; i < N; i++) begin
        if (obs_ready[i]) begin
          words[i]++;
          if (words[i] == 2) begin
            act_f[i] = 1'b0;
            words[i] = 0;
          end
        end
      end
      if (obs_grant != 0 && prev_g == 0) begin
        for (int i = 0; i < N; i++) if (obs_grant[i]) seq.push_back(i);
      end
      prev_g = obs_grant;
    end
    chk("f_grant_count", seq.size(), 5);
    for (int i = 0; i < seq.size(); i++) begin
      chk($sformatf("f_rotation%0d", i), seq[i], i % N);
    end

    // Random sessions, bursts and silences against the model
    do_reset();
    act_r = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 15) == 0) act_r[i] = ~act_r[i];
      end
      case ((c / 200) % 3)
        0: vprob = 90;
        1: vprob = 30;
        default: vprob = 0;
      endcase
      for (int i = 0; i < N; i++) val_r[i] = ($urandom_range(0, 99) < vprob);
      cycle(act_r, val_r, {$urandom, $urandom, $urandom, $urandom});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
